// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: MIG command encodings and the
// single-entry write-slot FSM state.
package fb_pkg;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_BOTH      = 2'd1,
        ST_CMD_ONLY  = 2'd2,
        ST_DATA_ONLY = 2'd3
    } wr_state_t;

endpackage

// File: rtl/fb_mig_writer.sv
// Single-entry chunk writer: turns 8-pixel chunks into MIG write command
// plus single-beat write data, tracking the two halves independently.
module fb_mig_writer
    import fb_pkg::*;
#(
    parameter int          HRES     = 1280,
    parameter int          VRES     = 720,
    parameter logic [26:0] FB0_BASE = 27'h0000000,
    parameter logic [26:0] FB1_BASE = 27'h0200000,
    localparam int         CAW      = $clog2(HRES * VRES / 8)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [CAW-1:0]    addr_in,
    input  logic [7:0][15:0]  data_in,
    input  logic [15:0]       strobe_in,
    input  logic              buffer_sel_in,
    output logic [26:0]       app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [127:0]      app_wdf_data,
    output logic [15:0]       app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic              clear_count_in,
    output logic [31:0]       write_count_out,
    output logic [31:0]       drop_count_out,
    output logic              idle_out
);

    wr_state_t   state, state_nxt;
    logic        accept, drop, load, txn_done;
    logic [26:0] base, chunk_off;

    assign accept    = valid_in && ready_out;
    assign drop      = accept && (strobe_in == 16'h0000);
    assign load      = accept && (strobe_in != 16'h0000);
    assign base      = buffer_sel_in ? FB1_BASE : FB0_BASE;
    assign chunk_off = 27'({addr_in, 3'b000});
    assign app_cmd   = MIG_CMD_WRITE;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_EMPTY;
        else           state <= state_nxt;
    end

    // txn_done marks the cycle the last outstanding half is handshaken;
    // the slot frees that same cycle so a new chunk can follow immediately.
    always_comb begin
        state_nxt    = state;
        txn_done     = 1'b0;
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (load) state_nxt = ST_BOTH;
            end
            ST_BOTH: begin
                app_en       = 1'b1;
                app_wdf_wren = 1'b1;
                if (app_rdy && app_wdf_rdy) begin
                    txn_done  = 1'b1;
                    state_nxt = load ? ST_BOTH : ST_EMPTY;
                end else if (app_rdy) begin
                    state_nxt = ST_DATA_ONLY;
                end else if (app_wdf_rdy) begin
                    state_nxt = ST_CMD_ONLY;
                end
            end
            ST_CMD_ONLY: begin
                app_en = 1'b1;
                if (app_rdy) begin
                    txn_done  = 1'b1;
                    state_nxt = load ? ST_BOTH : ST_EMPTY;
                end
            end
            ST_DATA_ONLY: begin
                app_wdf_wren = 1'b1;
                if (app_wdf_rdy) begin
                    txn_done  = 1'b1;
                    state_nxt = load ? ST_BOTH : ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        app_wdf_end = app_wdf_wren;
        ready_out   = (state == ST_EMPTY) || txn_done;
        idle_out    = (state == ST_EMPTY);
    end

    // Held entry only changes on a real load, so it stays stable while stalled.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            app_addr     <= '0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
        end else if (load) begin
            app_addr     <= base + chunk_off;
            app_wdf_data <= data_in;
            app_wdf_mask <= ~strobe_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            write_count_out <= '0;
            drop_count_out  <= '0;
        end else if (clear_count_in) begin
            write_count_out <= '0;
            drop_count_out  <= '0;
        end else begin
            if (txn_done) write_count_out <= write_count_out + 32'd1;
            if (drop)     drop_count_out  <= drop_count_out + 32'd1;
        end
    end

endmodule

// File: tb/tb_fb_mig_writer.sv
// Bench for fb_mig_writer: directed scenarios plus a randomized run
// checked against a queue-based model of pending command/data halves.
module tb_fb_mig_writer;

    localparam int CAW = 17;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic             valid_in = 1'b0;
    logic             ready_out;
    logic [CAW-1:0]   addr_in = '0;
    logic [7:0][15:0] data_in = '0;
    logic [15:0]      strobe_in = '0;
    logic             buffer_sel_in = 1'b0;
    logic [26:0]      app_addr;
    logic [2:0]       app_cmd;
    logic             app_en;
    logic             app_rdy = 1'b0;
    logic [127:0]     app_wdf_data;
    logic [15:0]      app_wdf_mask;
    logic             app_wdf_wren;
    logic             app_wdf_end;
    logic             app_wdf_rdy = 1'b0;
    logic             clear_count_in = 1'b0;
    logic [31:0]      write_count_out;
    logic [31:0]      drop_count_out;
    logic             idle_out;

    int checks = 0;
    int failures = 0;

    fb_mig_writer dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
        .addr_in(addr_in), .data_in(data_in), .strobe_in(strobe_in),
        .buffer_sel_in(buffer_sel_in), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .clear_count_in(clear_count_in),
        .write_count_out(write_count_out), .drop_count_out(drop_count_out), .idle_out(idle_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [26:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } txn_t;

    function automatic logic [127:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        @(negedge clk_in); #1;
        checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL rst_app_en got=%0h exp=0", app_en); end
        checks++; if (app_wdf_wren !== 1'b0) begin failures++; $display("FAIL rst_wren got=%0h exp=0", app_wdf_wren); end
        checks++; if (app_wdf_end !== 1'b0) begin failures++; $display("FAIL rst_end got=%0h exp=0", app_wdf_end); end
        checks++; if (app_addr !== 27'h0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", app_addr); end
        checks++; if (app_wdf_data !== 128'h0) begin failures++; $display("FAIL rst_data got=%0h exp=0", app_wdf_data); end
        checks++; if (app_wdf_mask !== 16'h0) begin failures++; $display("FAIL rst_mask got=%0h exp=0", app_wdf_mask); end
        checks++; if (write_count_out !== 32'd0) begin failures++; $display("FAIL rst_wcount got=%0d exp=0", write_count_out); end
        checks++; if (drop_count_out !== 32'd0) begin failures++; $display("FAIL rst_dcount got=%0d exp=0", drop_count_out); end
        checks++; if (idle_out !== 1'b1) begin failures++; $display("FAIL rst_idle got=%0h exp=1", idle_out); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", ready_out); end
    endtask

    task automatic test_single(input logic sel, input logic [CAW-1:0] a,
                               input logic [26:0] exp_addr, input logic [31:0] exp_wc);
        logic [127:0] d;
        d = rand_data();
        @(negedge clk_in);
        valid_in = 1'b1; addr_in = a; buffer_sel_in = sel; strobe_in = 16'hFFFF; data_in = d;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL single_ready got=%0h exp=1", ready_out); end
        @(negedge clk_in);
        valid_in = 1'b0;
        #1;
        checks++; if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin
            failures++; $display("FAIL single_strobes got=%0b%0b%0b exp=111", app_en, app_wdf_wren, app_wdf_end); end
        checks++; if (app_addr !== exp_addr) begin failures++; $display("FAIL single_addr got=%0h exp=%0h", app_addr, exp_addr); end
        checks++; if (app_wdf_mask !== 16'h0) begin failures++; $display("FAIL single_mask got=%0h exp=0", app_wdf_mask); end
        checks++; if (app_wdf_data !== d) begin failures++; $display("FAIL single_data got=%0h exp=%0h", app_wdf_data, d); end
        checks++; if (app_cmd !== 3'b000) begin failures++; $display("FAIL single_cmd got=%0h exp=0", app_cmd); end
        @(negedge clk_in); #1;
        checks++; if (app_en !== 1'b0 || idle_out !== 1'b1) begin
            failures++; $display("FAIL single_after got en=%0b idle=%0b exp en=0 idle=1", app_en, idle_out); end
        checks++; if (write_count_out !== exp_wc) begin failures++; $display("FAIL single_wcount got=%0d exp=%0d", write_count_out, exp_wc); end
    endtask

    task automatic test_data_stall();
        logic [127:0] d;
        d = rand_data();
        @(negedge clk_in);
        valid_in = 1'b1; addr_in = 17'd3; buffer_sel_in = 1'b0; strobe_in = 16'h00FF; data_in = d;
        app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL stall_accept got=%0h exp=1", ready_out); end
        @(negedge clk_in);
        valid_in = 1'b0;
        #1;
        checks++; if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || ready_out !== 1'b0) begin
            failures++; $display("FAIL stall_c1 got en=%0b wren=%0b rdy=%0b exp 1 1 0", app_en, app_wdf_wren, ready_out); end
        checks++; if (app_wdf_mask !== 16'hFF00) begin failures++; $display("FAIL stall_mask got=%0h exp=ff00", app_wdf_mask); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_in);
            if (c == 1) app_wdf_rdy = 1'b1;
            #1;
            checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin
                failures++; $display("FAIL stall_hold got en=%0b wren=%0b end=%0b exp 0 1 1", app_en, app_wdf_wren, app_wdf_end); end
            checks++; if (ready_out !== (c == 1)) begin failures++; $display("FAIL stall_ready got=%0b exp=%0b", ready_out, (c == 1)); end
            checks++; if (app_wdf_data !== d) begin failures++; $display("FAIL stall_data got=%0h exp=%0h", app_wdf_data, d); end
            checks++; if (write_count_out !== 32'd2) begin failures++; $display("FAIL stall_wcount_mid got=%0d exp=2", write_count_out); end
        end
        @(negedge clk_in); #1;
        checks++; if (app_wdf_wren !== 1'b0 || idle_out !== 1'b1) begin
            failures++; $display("FAIL stall_end got wren=%0b idle=%0b exp 0 1", app_wdf_wren, idle_out); end
        checks++; if (write_count_out !== 32'd3) begin failures++; $display("FAIL stall_wcount got=%0d exp=3", write_count_out); end
    endtask

    task automatic test_drop();
        @(negedge clk_in);
        valid_in = 1'b1; addr_in = 17'd7; strobe_in = 16'h0000; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL drop_ready got=%0h exp=1", ready_out); end
        @(negedge clk_in);
        valid_in = 1'b0;
        #1;
        checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || idle_out !== 1'b1) begin
            failures++; $display("FAIL drop_nocmd got en=%0b wren=%0b idle=%0b exp 0 0 1", app_en, app_wdf_wren, idle_out); end
        checks++; if (drop_count_out !== 32'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", drop_count_out); end
        checks++; if (write_count_out !== 32'd3) begin failures++; $display("FAIL drop_wcount got=%0d exp=3", write_count_out); end
    endtask

    task automatic test_clear();
        @(negedge clk_in);
        clear_count_in = 1'b1;
        @(negedge clk_in);
        clear_count_in = 1'b0;
        #1;
        checks++; if (write_count_out !== 32'd0 || drop_count_out !== 32'd0) begin
            failures++; $display("FAIL clear got w=%0d d=%0d exp 0 0", write_count_out, drop_count_out); end
    endtask

    task automatic test_back_to_back();
        int en_cycles;
        en_cycles = 0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; buffer_sel_in = 1'b0; strobe_in = 16'hFFFF;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk_in);
            valid_in = (i < 10);
            addr_in = 17'(i + 16);
            data_in = rand_data();
            #1;
            if (i > 0) begin
                if (app_en === 1'b1) en_cycles++;
                checks++; if (app_addr !== 27'((i - 1 + 16) * 8)) begin
                    failures++; $display("FAIL b2b_addr got=%0h exp=%0h", app_addr, 27'((i - 1 + 16) * 8)); end
            end
            if (i < 10) begin
                checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", ready_out); end
            end
        end
        @(negedge clk_in); #1;
        checks++; if (en_cycles != 10) begin failures++; $display("FAIL b2b_en_cycles got=%0d exp=10", en_cycles); end
        checks++; if (write_count_out !== 32'd10) begin failures++; $display("FAIL b2b_wcount got=%0d exp=10", write_count_out); end
        checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL b2b_en_after got=%0b exp=0", app_en); end
    endtask

    task automatic test_async_reset();
        @(negedge clk_in);
        valid_in = 1'b1; addr_in = 17'd9; strobe_in = 16'hFFFF; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        @(negedge clk_in);
        valid_in = 1'b0;
        #1;
        checks++; if (app_en !== 1'b1 || idle_out !== 1'b0) begin
            failures++; $display("FAIL areset_pre got en=%0b idle=%0b exp 1 0", app_en, idle_out); end
        #1 rst_n_in = 1'b0;
        #1;
        checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || idle_out !== 1'b1) begin
            failures++; $display("FAIL areset_ctl got en=%0b wren=%0b idle=%0b exp 0 0 1", app_en, app_wdf_wren, idle_out); end
        checks++; if (write_count_out !== 32'd0 || drop_count_out !== 32'd0 || app_addr !== 27'h0) begin
            failures++; $display("FAIL areset_regs got w=%0d d=%0d a=%0h exp 0 0 0", write_count_out, drop_count_out, app_addr); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1 || idle_out !== 1'b1) begin
            failures++; $display("FAIL areset_release got rdy=%0b idle=%0b exp 1 1", ready_out, idle_out); end
    endtask

    task automatic test_random();
        txn_t cmd_q[$];
        txn_t dat_q[$];
        txn_t t;
        logic [31:0] m_wc, m_dc;
        logic exp_ready, pend, done, drop_ev;
        m_wc = 0; m_dc = 0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk_in);
            valid_in       = ($urandom_range(0, 9) < 7);
            addr_in        = 17'($urandom_range(0, (1 << CAW) - 1));
            buffer_sel_in  = 1'($urandom_range(0, 1));
            data_in        = rand_data();
            strobe_in      = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            app_rdy        = ($urandom_range(0, 9) < 6);
            app_wdf_rdy    = ($urandom_range(0, 9) < 6);
            clear_count_in = ($urandom_range(0, 31) == 0);
            #1;
            exp_ready = (cmd_q.size() == 0 || app_rdy) && (dat_q.size() == 0 || app_wdf_rdy);
            checks++; if (ready_out !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", n, ready_out, exp_ready); end
            checks++; if (app_en !== (cmd_q.size() != 0)) begin failures++; $display("FAIL rnd_en cyc=%0d got=%0b exp=%0b", n, app_en, (cmd_q.size() != 0)); end
            checks++; if (app_wdf_wren !== (dat_q.size() != 0) || app_wdf_end !== (dat_q.size() != 0)) begin
                failures++; $display("FAIL rnd_wren cyc=%0d got=%0b/%0b exp=%0b", n, app_wdf_wren, app_wdf_end, (dat_q.size() != 0)); end
            checks++; if (idle_out !== (cmd_q.size() == 0 && dat_q.size() == 0)) begin
                failures++; $display("FAIL rnd_idle cyc=%0d got=%0b", n, idle_out); end
            checks++; if (write_count_out !== m_wc) begin failures++; $display("FAIL rnd_wcount cyc=%0d got=%0d exp=%0d", n, write_count_out, m_wc); end
            checks++; if (drop_count_out !== m_dc) begin failures++; $display("FAIL rnd_dcount cyc=%0d got=%0d exp=%0d", n, drop_count_out, m_dc); end
            checks++; if (app_cmd !== 3'b000) begin failures++; $display("FAIL rnd_cmd cyc=%0d got=%0h exp=0", n, app_cmd); end
            if (cmd_q.size() != 0) begin
                checks++; if (app_addr !== cmd_q[0].addr) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%0h exp=%0h", n, app_addr, cmd_q[0].addr); end
            end
            if (dat_q.size() != 0) begin
                checks++; if (app_wdf_data !== dat_q[0].data || app_wdf_mask !== dat_q[0].mask) begin
                    failures++; $display("FAIL rnd_wdata cyc=%0d got=%0h/%0h exp=%0h/%0h", n, app_wdf_data, app_wdf_mask, dat_q[0].data, dat_q[0].mask); end
            end
            pend = (cmd_q.size() != 0) || (dat_q.size() != 0);
            if (cmd_q.size() != 0 && app_rdy) void'(cmd_q.pop_front());
            if (dat_q.size() != 0 && app_wdf_rdy) void'(dat_q.pop_front());
            done = pend && cmd_q.size() == 0 && dat_q.size() == 0;
            drop_ev = 1'b0;
            if (valid_in && exp_ready) begin
                if (strobe_in == 16'h0000) begin
                    drop_ev = 1'b1;
                end else begin
                    t.addr = (buffer_sel_in ? 27'h0200000 : 27'h0000000) + 27'(addr_in) * 27'd8;
                    t.data = data_in;
                    t.mask = ~strobe_in;
                    cmd_q.push_back(t);
                    dat_q.push_back(t);
                end
            end
            if (clear_count_in) begin
                m_wc = 0; m_dc = 0;
            end else begin
                m_wc = m_wc + 32'(done);
                m_dc = m_dc + 32'(drop_ev);
            end
        end
        @(negedge clk_in);
        valid_in = 1'b0; clear_count_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single(1'b0, 17'd5, 27'h0000028, 32'd1);
        test_single(1'b1, 17'd1, 27'h0200008, 32'd2);
        test_data_stall();
        test_drop();
        test_clear();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
